// File: rtl/dmem_pipe.sv
// Pipelined data memory with configurable width, depth and read latency.
// Optional per-word even parity enabled by defining DMEM_PARITY_EN.
module dmem_pipe #(
  parameter int WIDTH   = 48,
  parameter int AWIDTH  = 15,
  parameter int DEPTH   = 32768,
  parameter int LATENCY = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [AWIDTH-1:0] i_addr,
  input  logic              i_read,
  input  logic              i_write,
  input  logic [WIDTH-1:0]  i_data,
`ifdef DMEM_PARITY_EN
  input  logic              i_inject_err,
`endif
  output logic [WIDTH-1:0]  o_data,
  output logic              o_done,
  output logic              o_error
);

  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
`ifdef DMEM_PARITY_EN
  localparam int MW = WIDTH + 1;
`else
  localparam int MW = WIDTH;
`endif

  logic [MW-1:0]      r_mem [0:DEPTH-1];
  logic [LATENCY-1:0] r_vld;
  logic [LATENCY-1:0] r_rd;
  logic [LATENCY-1:0] r_rerr;
  logic [MW-1:0]      r_word [LATENCY];

  logic          w_in_range;
  logic          w_accept;
  logic          w_we;
  logic [IW-1:0] w_idx;
  logic [MW-1:0] w_wr_word;
  logic          w_word_bad;

  assign w_in_range = ({1'b0, i_addr} < (AWIDTH+1)'(DEPTH));
  assign w_accept   = ~reset & (i_read | i_write);
  assign w_we       = ~reset & i_write & w_in_range;
  assign w_idx      = i_addr[IW-1:0];

`ifdef DMEM_PARITY_EN
  assign w_wr_word  = {(^i_data) ^ i_inject_err, i_data};
  // Stored word carries even parity, so any odd reduction means corruption.
  assign w_word_bad = ^r_word[LATENCY-1];
`else
  assign w_wr_word  = i_data;
  assign w_word_bad = 1'b0;
`endif

  // Read-first: an exchange samples the old word on the same edge it is overwritten.
  always_ff @(posedge clk) begin
    if (w_we) r_mem[w_idx] <= w_wr_word;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_vld  <= '0;
      r_rd   <= '0;
      r_rerr <= '0;
      for (int k = 0; k < LATENCY; k++) r_word[k] <= '0;
    end else begin
      r_vld[0]  <= w_accept;
      r_rd[0]   <= w_accept & i_read;
      r_rerr[0] <= w_accept & ~w_in_range;
      if (w_accept && i_read) r_word[0] <= w_in_range ? r_mem[w_idx] : '0;
      // Only the output stage is gated, so o_data holds across write-only completions.
      for (int k = 1; k < LATENCY; k++) begin
        r_vld[k]  <= r_vld[k-1];
        r_rd[k]   <= r_rd[k-1];
        r_rerr[k] <= r_rerr[k-1];
        if ((k < LATENCY-1) || (r_vld[k-1] && r_rd[k-1])) r_word[k] <= r_word[k-1];
      end
    end
  end

  assign o_done  = r_vld[LATENCY-1];
  assign o_data  = r_word[LATENCY-1][WIDTH-1:0];
  assign o_error = r_vld[LATENCY-1] & (r_rerr[LATENCY-1] | (r_rd[LATENCY-1] & w_word_bad));

endmodule

// File: tb/tb_dmem_pipe.sv
// Table-driven bench for dmem_pipe: one op stream drives LATENCY 1, 3 and 4 instances.
// Parity vectors expect faults only when DMEM_PARITY_EN is defined.
module tb_dmem_pipe;
  localparam int W  = 48;
  localparam int AW = 15;
  localparam int D  = 1024;
`ifdef DMEM_PARITY_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif

  typedef struct {
    logic          rd;
    logic          wr;
    logic          inj;
    logic [AW-1:0] addr;
    logic [W-1:0]  wdata;
    logic          done;
    logic          err;
    logic [W-1:0]  rdata;
  } vec_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [AW-1:0] addr = '0;
  logic rd = 1'b0, wr = 1'b0, inj = 1'b0;
  logic [W-1:0] wdata = '0;
  logic [W-1:0] d1, d3, d4;
  logic dn1, dn3, dn4, er1, er3, er4;

  int total = 0;
  int bad = 0;
  vec_t vecs[$];

  always #5 clk = ~clk;

  dmem_pipe #(.WIDTH(W), .AWIDTH(AW), .DEPTH(D), .LATENCY(1)) u_l1 (
    .clk(clk), .reset(reset), .i_addr(addr), .i_read(rd), .i_write(wr), .i_data(wdata),
`ifdef DMEM_PARITY_EN
    .i_inject_err(inj),
`endif
    .o_data(d1), .o_done(dn1), .o_error(er1));

  dmem_pipe #(.WIDTH(W), .AWIDTH(AW), .DEPTH(D), .LATENCY(3)) u_l3 (
    .clk(clk), .reset(reset), .i_addr(addr), .i_read(rd), .i_write(wr), .i_data(wdata),
`ifdef DMEM_PARITY_EN
    .i_inject_err(inj),
`endif
    .o_data(d3), .o_done(dn3), .o_error(er3));

  dmem_pipe #(.WIDTH(W), .AWIDTH(AW), .DEPTH(D), .LATENCY(4)) u_l4 (
    .clk(clk), .reset(reset), .i_addr(addr), .i_read(rd), .i_write(wr), .i_data(wdata),
`ifdef DMEM_PARITY_EN
    .i_inject_err(inj),
`endif
    .o_data(d4), .o_done(dn4), .o_error(er4));

  task automatic add(input logic r, input logic w, input logic [AW-1:0] a, input logic [W-1:0] wd,
                     input logic ij, input logic dn, input logic er, input logic [W-1:0] rdv);
    vec_t v;
    v.rd = r; v.wr = w; v.addr = a; v.wdata = wd; v.inj = ij;
    v.done = dn; v.err = er; v.rdata = rdv;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input int lat, input int idx,
                     input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s L%0d op%0d: got %h expected %h", name, lat, idx, act, exp);
    end
  endtask

  task automatic get_out(input int lat, output logic dn, output logic er, output logic [W-1:0] dt);
    case (lat)
      1:       begin dn = dn1; er = er1; dt = d1; end
      3:       begin dn = dn3; er = er3; dt = d3; end
      default: begin dn = dn4; er = er4; dt = d4; end
    endcase
  endtask

  task automatic drive(input logic r, input logic w, input logic [AW-1:0] a,
                       input logic [W-1:0] wd, input logic ij);
    rd = r; wr = w; addr = a; wdata = wd; inj = ij;
  endtask

  initial begin
    int lats[3];
    logic dn, er;
    logic [W-1:0] dt;
    int n;
    lats[0] = 1; lats[1] = 3; lats[2] = 4;

    //   rd    wr    addr     wdata              inj   done  err   rdata
    add(1'b0, 1'b1, 15'h123, 48'hABCDEF012345, 1'b0, 1'b1, 1'b0, 48'h0);
    add(1'b1, 1'b0, 15'h123, 48'h0,            1'b0, 1'b1, 1'b0, 48'hABCDEF012345);
    add(1'b0, 1'b1, 15'h000, 48'h1,            1'b0, 1'b1, 1'b0, 48'hABCDEF012345);
    add(1'b0, 1'b1, 15'h001, 48'h2,            1'b0, 1'b1, 1'b0, 48'hABCDEF012345);
    add(1'b0, 1'b1, 15'h002, 48'h3,            1'b0, 1'b1, 1'b0, 48'hABCDEF012345);
    add(1'b0, 1'b1, 15'h003, 48'h4,            1'b0, 1'b1, 1'b0, 48'hABCDEF012345);
    add(1'b1, 1'b0, 15'h000, 48'h0,            1'b0, 1'b1, 1'b0, 48'h1);
    add(1'b1, 1'b0, 15'h001, 48'h0,            1'b0, 1'b1, 1'b0, 48'h2);
    add(1'b1, 1'b0, 15'h002, 48'h0,            1'b0, 1'b1, 1'b0, 48'h3);
    add(1'b1, 1'b0, 15'h003, 48'h0,            1'b0, 1'b1, 1'b0, 48'h4);
    add(1'b0, 1'b0, 15'h000, 48'h0,            1'b0, 1'b0, 1'b0, 48'h4);
    add(1'b0, 1'b1, 15'h005, 48'h111,          1'b0, 1'b1, 1'b0, 48'h4);
    add(1'b1, 1'b1, 15'h005, 48'h222,          1'b0, 1'b1, 1'b0, 48'h111);
    add(1'b1, 1'b0, 15'h005, 48'h0,            1'b0, 1'b1, 1'b0, 48'h222);
    add(1'b0, 1'b1, 15'h400, 48'h5A,           1'b0, 1'b1, 1'b1, 48'h222);
    add(1'b1, 1'b0, 15'h400, 48'h0,            1'b0, 1'b1, 1'b1, 48'h0);
    add(1'b1, 1'b0, 15'h000, 48'h0,            1'b0, 1'b1, 1'b0, 48'h1);
    add(1'b0, 1'b1, 15'h3FF, 48'hFFFFFFFFFFFF, 1'b0, 1'b1, 1'b0, 48'h1);
    add(1'b1, 1'b0, 15'h3FF, 48'h0,            1'b0, 1'b1, 1'b0, 48'hFFFFFFFFFFFF);
    add(1'b1, 1'b0, 15'h7FFF, 48'h0,           1'b0, 1'b1, 1'b1, 48'h0);
    add(1'b0, 1'b0, 15'h000, 48'h0,            1'b0, 1'b0, 1'b0, 48'h0);
    add(1'b0, 1'b1, 15'h007, 48'hFFFF,         1'b1, 1'b1, 1'b0, 48'h0);
    add(1'b1, 1'b0, 15'h007, 48'h0,            1'b0, 1'b1, PAR,  48'hFFFF);
    add(1'b0, 1'b1, 15'h007, 48'hFFFF,         1'b0, 1'b1, 1'b0, 48'hFFFF);
    add(1'b1, 1'b0, 15'h007, 48'h0,            1'b0, 1'b1, 1'b0, 48'hFFFF);
    add(1'b1, 1'b1, 15'h007, 48'h1234,         1'b1, 1'b1, 1'b0, 48'hFFFF);
    add(1'b1, 1'b0, 15'h007, 48'h0,            1'b0, 1'b1, PAR,  48'h1234);
    n = vecs.size();

    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    for (int j = 0; j < 3; j++) begin
      get_out(lats[j], dn, er, dt);
      chk("reset_done", lats[j], -1, 64'(dn), 64'(1'b0));
      chk("reset_err",  lats[j], -1, 64'(er), 64'(1'b0));
      chk("reset_data", lats[j], -1, 64'(dt), 64'(0));
    end

    for (int e = 0; e < n + 3; e++) begin
      @(negedge clk);
      if (e < n) drive(vecs[e].rd, vecs[e].wr, vecs[e].addr, vecs[e].wdata, vecs[e].inj);
      else       drive(1'b0, 1'b0, '0, '0, 1'b0);
      @(posedge clk);
      #1;
      for (int j = 0; j < 3; j++) begin
        int idx;
        idx = e - lats[j] + 1;
        get_out(lats[j], dn, er, dt);
        if (idx < 0) begin
          chk("lead_done", lats[j], idx, 64'(dn), 64'(1'b0));
          chk("lead_data", lats[j], idx, 64'(dt), 64'(0));
        end else if (idx < n) begin
          chk("done", lats[j], idx, 64'(dn), 64'(vecs[idx].done));
          chk("err",  lats[j], idx, 64'(er), 64'(vecs[idx].err));
          chk("data", lats[j], idx, 64'(dt), 64'(vecs[idx].rdata));
        end else begin
          chk("tail_done", lats[j], idx, 64'(dn), 64'(1'b0));
          chk("tail_err",  lats[j], idx, 64'(er), 64'(1'b0));
        end
      end
    end

    // Read in flight, reset two cycles later with a write that must be ignored.
    @(negedge clk);
    drive(1'b1, 1'b0, 15'h123, '0, 1'b0);
    @(posedge clk); #1;
    chk("mf_l1_done", 1, 0, 64'(dn1), 64'(1'b1));
    chk("mf_l1_data", 1, 0, 64'(d1), 64'(48'hABCDEF012345));
    @(negedge clk);
    drive(1'b0, 1'b0, '0, '0, 1'b0);
    @(posedge clk); #1;
    chk("mf_l4_early", 4, 1, 64'(dn4), 64'(1'b0));
    @(negedge clk);
    reset = 1'b1;
    drive(1'b0, 1'b1, 15'h123, 48'h0, 1'b0);
    @(posedge clk); #1;
    @(negedge clk);
    reset = 1'b0;
    drive(1'b0, 1'b0, '0, '0, 1'b0);
    for (int j = 0; j < 3; j++) begin
      get_out(lats[j], dn, er, dt);
      chk("mf_rst_done", lats[j], 2, 64'(dn), 64'(1'b0));
      chk("mf_rst_err",  lats[j], 2, 64'(er), 64'(1'b0));
      chk("mf_rst_data", lats[j], 2, 64'(dt), 64'(0));
    end
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      chk("mf_drop_l3", 3, c, 64'(dn3), 64'(1'b0));
      chk("mf_drop_l4", 4, c, 64'(dn4), 64'(1'b0));
    end

    @(negedge clk);
    drive(1'b1, 1'b0, 15'h123, '0, 1'b0);
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      if (k == 0) begin
        @(negedge clk);
        drive(1'b0, 1'b0, '0, '0, 1'b0);
      end
      for (int j = 0; j < 3; j++) begin
        get_out(lats[j], dn, er, dt);
        chk("post_done", lats[j], k, 64'(dn), 64'(k == lats[j] - 1));
        chk("post_data", lats[j], k, 64'(dt), (k >= lats[j] - 1) ? 64'(48'hABCDEF012345) : 64'(0));
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
